alu_decode_stage: RTL and testbench

Decode-to-execute pipeline stage that generates the ALU's operand and operation interface. It accepts a fetched RV32IM instruction with its PC and register-file read data, and decodes the opcode, funct3 and funct7 fields into the 5-bit ALU operation code. It selects the ALU A/B operands, extracts the immediate, and registers everything behind a valid/ready handshake with stall and flush. It sits between the register-file read and the execute stage, whose ALU consumes `out_a`, `out_b` and `out_aluc`.

---
 rtl/alu_decode_stage.sv | 256 +++++++++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: RV32IM decode-to-execute register stage.
// Decodes opcode/funct3/funct7 into a 5-bit ALU op, selects operands A/B,
// extracts the immediate and registers the result behind valid/ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   in_instr, in_pc     instruction word and its PC
//   in_rs1/2_data       forwarded register read data
//   flush               kill held and incoming instruction
//   out_valid/out_ready output handshake
//   out_a/b/aluc        ALU operands and operation
//   out_imm/pc/rd/wen   immediate, PC, destination, write enable
//   out_is_*            class flags; out_illegal unsupported encoding
module alu_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [4:0]  out_aluc,
  output logic [31:0] out_imm,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_is_branch,
  output logic        out_is_load,
  output logic        out_is_store,
  output logic        out_is_jump,
  output logic        out_is_muldiv,
  output logic        out_illegal
);

  localparam logic [4:0] ALU_ADD = 5'b00000, ALU_SUB = 5'b00001, ALU_SLT = 5'b00010,
                         ALU_SLL = 5'b00011, ALU_OR  = 5'b00100, ALU_AND = 5'b00101,
                         ALU_LUI = 5'b00110, ALU_SRL = 5'b00111, ALU_MUL = 5'b01000,
                         ALU_BEQ = 5'b01001, ALU_BNE = 5'b01010, ALU_XOR = 5'b01011,
                         ALU_DIV = 5'b01100, ALU_REM = 5'b01101, ALU_SRA = 5'b01111,
                         ALU_MULH = 5'b10000, ALU_MULHSU = 5'b10001, ALU_MULHU = 5'b10010,
                         ALU_DIVU = 5'b11000, ALU_BLT = 5'b11001, ALU_BGE = 5'b11010,
                         ALU_REMU = 5'b11101;

  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LUI = 7'b0110111,
                         OPC_AUIPC = 7'b0010111, OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011,
                         OPC_BRANCH = 7'b1100011, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MUL = 7'b0000001;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  aluc;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
    logic        is_jump;
    logic        is_muldiv;
    logic        illegal;
  } dec_t;

  dec_t dec_c, dec_q;
  logic valid_q;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        writes, illegal;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  // Combinational decode of the incoming instruction
  always_comb begin
    dec_c      = '0;
    dec_c.a    = in_rs1_data;
    dec_c.b    = in_rs2_data;
    dec_c.pc   = in_pc;
    dec_c.rd   = rd;
    dec_c.aluc = ALU_ADD;
    writes     = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OPC_OP: begin
        writes = 1'b1;
        case (funct7)
          F7_BASE: begin
            case (funct3)
              3'b000:  dec_c.aluc = ALU_ADD;
              3'b001:  dec_c.aluc = ALU_SLL;
              3'b010:  dec_c.aluc = ALU_SLT;
              3'b100:  dec_c.aluc = ALU_XOR;
              3'b101:  dec_c.aluc = ALU_SRL;
              3'b110:  dec_c.aluc = ALU_OR;
              3'b111:  dec_c.aluc = ALU_AND;
              default: illegal    = 1'b1;   // SLTU
            endcase
          end
          F7_ALT: begin
            case (funct3)
              3'b000:  dec_c.aluc = ALU_SUB;
              3'b101:  dec_c.aluc = ALU_SRA;
              default: illegal    = 1'b1;
            endcase
          end
          F7_MUL: begin
            dec_c.is_muldiv = 1'b1;
            case (funct3)
              3'b000:  dec_c.aluc = ALU_MUL;
              3'b001:  dec_c.aluc = ALU_MULH;
              3'b010:  dec_c.aluc = ALU_MULHSU;
              3'b011:  dec_c.aluc = ALU_MULHU;
              3'b100:  dec_c.aluc = ALU_DIV;
              3'b101:  dec_c.aluc = ALU_DIVU;
              3'b110:  dec_c.aluc = ALU_REM;
              default: dec_c.aluc = ALU_REMU;
            endcase
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        writes    = 1'b1;
        dec_c.b   = imm_i;
        dec_c.imm = imm_i;
        case (funct3)
          3'b000: dec_c.aluc = ALU_ADD;
          3'b010: dec_c.aluc = ALU_SLT;
          3'b100: dec_c.aluc = ALU_XOR;
          3'b110: dec_c.aluc = ALU_OR;
          3'b111: dec_c.aluc = ALU_AND;
          3'b001: begin
            dec_c.aluc = ALU_SLL;
            dec_c.b    = {27'b0, in_instr[24:20]};
            illegal    = (funct7 != F7_BASE);
          end
          3'b101: begin
            dec_c.b = {27'b0, in_instr[24:20]};
            if (funct7 == F7_BASE)     dec_c.aluc = ALU_SRL;
            else if (funct7 == F7_ALT) dec_c.aluc = ALU_SRA;
            else                       illegal    = 1'b1;
          end
          default: illegal = 1'b1;    // SLTIU
        endcase
      end
      OPC_LUI: begin
        writes     = 1'b1;
        dec_c.aluc = ALU_LUI;
        dec_c.a    = '0;
        dec_c.b    = imm_u;
        dec_c.imm  = imm_u;
      end
      OPC_AUIPC: begin
        writes    = 1'b1;
        dec_c.a   = in_pc;
        dec_c.b   = imm_u;
        dec_c.imm = imm_u;
      end
      OPC_LOAD: begin
        writes        = 1'b1;
        dec_c.is_load = 1'b1;
        dec_c.b       = imm_i;
        dec_c.imm     = imm_i;
      end
      OPC_STORE: begin
        dec_c.is_store = 1'b1;
        dec_c.b        = imm_s;
        dec_c.imm      = imm_s;
      end
      OPC_BRANCH: begin
        dec_c.is_branch = 1'b1;
        dec_c.imm       = imm_b;
        case (funct3)
          3'b000:  dec_c.aluc = ALU_BEQ;
          3'b001:  dec_c.aluc = ALU_BNE;
          3'b100:  dec_c.aluc = ALU_BLT;
          3'b101:  dec_c.aluc = ALU_BGE;
          default: illegal    = 1'b1;   // BLTU/BGEU and reserved
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        // ALU computes the link address pc+4; target offset rides in imm
        writes        = 1'b1;
        dec_c.is_jump = 1'b1;
        dec_c.a       = in_pc;
        dec_c.b       = 32'd4;
        dec_c.imm     = (opcode == OPC_JAL) ? imm_j : imm_i;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      dec_c.aluc      = ALU_ADD;
      dec_c.is_branch = 1'b0;
      dec_c.is_load   = 1'b0;
      dec_c.is_store  = 1'b0;
      dec_c.is_jump   = 1'b0;
      dec_c.is_muldiv = 1'b0;
    end
    dec_c.illegal = illegal;
    dec_c.wen     = writes && !illegal && (rd != 5'd0);
  end

  assign in_ready = !valid_q || out_ready;

  // Output register: reset > flush > load > drain
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      dec_q   <= dec_c;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid     = valid_q;
  assign out_a         = dec_q.a;
  assign out_b         = dec_q.b;
  assign out_aluc      = dec_q.aluc;
  assign out_imm       = dec_q.imm;
  assign out_pc        = dec_q.pc;
  assign out_rd        = dec_q.rd;
  assign out_wen       = dec_q.wen;
  assign out_is_branch = dec_q.is_branch;
  assign out_is_load   = dec_q.is_load;
  assign out_is_store  = dec_q.is_store;
  assign out_is_jump   = dec_q.is_jump;
  assign out_is_muldiv = dec_q.is_muldiv;
  assign out_illegal   = dec_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: directed self-checking bench for alu_decode_stage.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
  logic [31:0] out_a, out_b, out_imm, out_pc;
  logic [4:0]  out_aluc, out_rd;
  logic        out_wen, out_is_branch, out_is_load, out_is_store, out_is_jump;
  logic        out_is_muldiv, out_illegal;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_aluc(out_aluc),
    .out_imm(out_imm), .out_pc(out_pc), .out_rd(out_rd), .out_wen(out_wen),
    .out_is_branch(out_is_branch), .out_is_load(out_is_load),
    .out_is_store(out_is_store), .out_is_jump(out_is_jump),
    .out_is_muldiv(out_is_muldiv), .out_illegal(out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid    = 1'b1;
    in_instr    = instr;
    in_pc       = pc;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
  endtask

  // Present one instruction for one accepted cycle, then drop in_valid
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2);
    drive(instr, pc, rs1, rs2);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_a", out_a, 32'd0);
    chk("rst_wen", 32'(out_wen), 32'd0);
    rst = 1'b0;

    // ADD x3,x1,x2
    send(32'h002081B3, 32'h100, 32'd5, 32'd7);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_aluc", 32'(out_aluc), 32'h00);
    chk("add_a", out_a, 32'd5);
    chk("add_b", out_b, 32'd7);
    chk("add_rd", 32'(out_rd), 32'd3);
    chk("add_wen", 32'(out_wen), 32'd1);
    chk("add_pc", out_pc, 32'h100);

    // Back-to-back SUB then MULHU
    drive(32'h402081B3, 32'h104, 32'd10, 32'd3);
    #1 chk("b2b_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("sub_aluc", 32'(out_aluc), 32'h01);
    chk("sub_muldiv", 32'(out_is_muldiv), 32'd0);
    chk("sub_a", out_a, 32'd10);
    drive(32'h027332B3, 32'h108, 32'd1, 32'd2);
    tick();
    chk("mulhu_valid", 32'(out_valid), 32'd1);
    chk("mulhu_aluc", 32'(out_aluc), 32'h12);
    chk("mulhu_muldiv", 32'(out_is_muldiv), 32'd1);
    chk("mulhu_rd", 32'(out_rd), 32'd5);

    // BLT then stall 3 cycles with LUI waiting on the input
    drive(32'h0020C063, 32'h10C, 32'd1, 32'd2);
    tick();
    out_ready = 1'b0;
    drive(32'h123450B7, 32'h110, 32'd9, 32'd9);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_aluc", 32'(out_aluc), 32'h19);
      chk("stall_wen", 32'(out_wen), 32'd0);
      chk("stall_branch", 32'(out_is_branch), 32'd1);
      chk("stall_pc", out_pc, 32'h10C);
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("lui_aluc", 32'(out_aluc), 32'h06);
    chk("lui_a", out_a, 32'd0);
    chk("lui_b", out_b, 32'h12345000);
    chk("lui_wen", 32'(out_wen), 32'd1);

    // ADDI x1,x0,-1
    send(32'hFFF00093, 32'h114, 32'd0, 32'd0);
    chk("addi_aluc", 32'(out_aluc), 32'h00);
    chk("addi_b", out_b, 32'hFFFFFFFF);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);

    // SLTU is illegal
    send(32'h0020B1B3, 32'h118, 32'd1, 32'd2);
    chk("sltu_valid", 32'(out_valid), 32'd1);
    chk("sltu_illegal", 32'(out_illegal), 32'd1);
    chk("sltu_aluc", 32'(out_aluc), 32'h00);
    chk("sltu_wen", 32'(out_wen), 32'd0);

    // Remaining ALU encodings and classes
    send(32'h4020D1B3, 32'h11C, 32'd1, 32'd2);
    chk("sra_aluc", 32'(out_aluc), 32'h0F);
    send(32'h0020C1B3, 32'h120, 32'd1, 32'd2);
    chk("xor_aluc", 32'(out_aluc), 32'h0B);
    send(32'h40315093, 32'h124, 32'd77, 32'd2);
    chk("srai_aluc", 32'(out_aluc), 32'h0F);
    chk("srai_b", out_b, 32'd3);
    chk("srai_a", out_a, 32'd77);
    send(32'h0220C1B3, 32'h128, 32'd1, 32'd2);
    chk("div_aluc", 32'(out_aluc), 32'h0C);
    chk("div_muldiv", 32'(out_is_muldiv), 32'd1);
    send(32'h008000EF, 32'h200, 32'd1, 32'd2);
    chk("jal_a", out_a, 32'h200);
    chk("jal_b", out_b, 32'd4);
    chk("jal_imm", out_imm, 32'd8);
    chk("jal_jump", 32'(out_is_jump), 32'd1);
    chk("jal_wen", 32'(out_wen), 32'd1);
    send(32'h0020A223, 32'h204, 32'h1000, 32'd2);
    chk("sw_a", out_a, 32'h1000);
    chk("sw_b", out_b, 32'd4);
    chk("sw_store", 32'(out_is_store), 32'd1);
    chk("sw_wen", 32'(out_wen), 32'd0);
    send(32'h00208033, 32'h208, 32'd1, 32'd2);
    chk("add_x0_wen", 32'(out_wen), 32'd0);
    send(32'h202081B3, 32'h20C, 32'd1, 32'd2);
    chk("badf7_illegal", 32'(out_illegal), 32'd1);
    send(32'h0020E063, 32'h210, 32'd1, 32'd2);
    chk("bltu_illegal", 32'(out_illegal), 32'd1);
    chk("bltu_branch", 32'(out_is_branch), 32'd0);

    // Flush with a stalled instruction and a new incoming one
    out_ready = 1'b0;
    send(32'h002081B3, 32'h300, 32'd1, 32'd2);
    drive(32'h402081B3, 32'h304, 32'd1, 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    tick();
    chk("flush_stays_empty", 32'(out_valid), 32'd0);

    // Reset during a stall
    send(32'hFFF00093, 32'h400, 32'd1, 32'd2);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    drive(32'h002081B3, 32'h404, 32'd1, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_stall_valid", 32'(out_valid), 32'd0);
    chk("rst_stall_in_ready", 32'(in_ready), 32'd1);
    chk("rst_stall_b", out_b, 32'd0);
    chk("rst_stall_imm", out_imm, 32'd0);
    chk("rst_stall_pc", out_pc, 32'd0);
    chk("rst_stall_rd", 32'(out_rd), 32'd0);
    chk("rst_stall_wen", 32'(out_wen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
